// File: rtl/dff_pipeline_pkg.sv
// Shared types and helpers for the handshaked register pipeline.
package dff_pipeline_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_STAGES = 4;

    // Occupancy counter update selected each cycle.
    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,
        OCC_INC  = 2'd1,
        OCC_DEC  = 2'd2,
        OCC_CLR  = 2'd3
    } occ_op_e;

    // Width needed to count 0..stages valid words inclusive.
    function automatic int unsigned occ_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage : dff_pipeline_pkg

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid bit plus a data word, with load, flush and reset.
module dff_pipe_stage
    import dff_pipeline_pkg::*;
#(
    parameter int unsigned           WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: flush empties the slot; a load takes the upstream valid, data only when valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : dff_pipe_stage

// File: rtl/dff_pipeline.sv
// STAGES-deep, WIDTH-wide valid/ready register pipeline with bubble collapsing,
// synchronous flush and a registered occupancy count.
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      STAGES    = DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_w(STAGES)-1:0]     occupancy
);

    localparam int unsigned OCC_W = occ_w(STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } stage_t;

    stage_t            stage_in  [STAGES];
    stage_t            stage_out [STAGES];
    logic [STAGES-1:0] v_vec;
    logic [STAGES-1:0] rdy;

    logic              acc;
    logic              del;
    occ_op_e           occ_op;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    // Ready chain: a slot can load if it or any slot downstream of it is empty,
    // or the consumer takes the last word this cycle.
    always_comb begin
        logic chain;
        chain = out_ready;
        rdy   = '0;
        for (int i = int'(LAST); i >= 0; i--) begin
            chain  = chain | ~v_vec[i];
            rdy[i] = chain;
        end
    end

    assign in_ready = rdy[0] & ~flush & rst;

    // Slot chain: slot 0 fed by the input handshake, slot g by slot g-1.
    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_in[g].v = in_valid & in_ready;
            assign stage_in[g].d = in_data;
        end else begin : g_body
            assign stage_in[g] = stage_out[g-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (rdy[g]),
            .flush_i (flush),
            .valid_i (stage_in[g].v),
            .data_i  (stage_in[g].d),
            .valid_o (stage_out[g].v),
            .data_o  (stage_out[g].d)
        );

        assign v_vec[g] = stage_out[g].v;
    end

    assign out_valid = stage_out[LAST].v;
    assign out_data  = stage_out[LAST].d;

    assign acc = in_valid & in_ready;
    assign del = out_valid & out_ready;

    // Occupancy update selection; flush wins over any transfer.
    always_comb begin
        occ_op = OCC_HOLD;
        if (flush) begin
            occ_op = OCC_CLR;
        end else if (acc && !del) begin
            occ_op = OCC_INC;
        end else if (!acc && del) begin
            occ_op = OCC_DEC;
        end
    end

    // Occupancy next value from the selected update.
    always_comb begin
        occ_d = occ_q;
        case (occ_op)
            OCC_INC:  occ_d = occ_q + OCC_W'(1);
            OCC_DEC:  occ_d = occ_q - OCC_W'(1);
            OCC_CLR:  occ_d = '0;
            default:  occ_d = occ_q;
        endcase
    end

    // Occupancy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

    // Count always equals the number of valid slots and never exceeds the depth.
    a_occ_popcount : assert property (@(posedge clk) disable iff (!rst)
        32'(occ_q) == $countones(v_vec));

    a_occ_range : assert property (@(posedge clk) disable iff (!rst)
        32'(occ_q) <= STAGES);

    // A stalled output word must not change until it is taken or discarded.
    a_out_stable : assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule : dff_pipeline

// File: tb/tb_dff_pipeline.sv
// Randomised and directed bench for dff_pipeline against a word-position queue model.
module tb_dff_pipeline;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    int errors = 0;
    int checks = 0;

    // Model: queue of words in flight (oldest first) and each word's slot position.
    int  m_data[$];
    int  m_pos[$];
    bit  known = 0;
    int  dut_deliv = 0;

    dff_pipeline #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        return (m_pos.size() > 0) && (m_pos[0] == int'(STAGES) - 1);
    endfunction

    function automatic bit model_in_ready(input logic r, input logic fl, input logic ordy);
        return r && !fl && (ordy || (m_data.size() < int'(STAGES)));
    endfunction

    // Advance the model across one rising edge given the inputs held during the cycle.
    task automatic model_edge(input logic r, input logic iv, input logic [WIDTH-1:0] id,
                              input logic fl, input logic ordy);
        bit acc;
        bit dlv;
        acc = iv && model_in_ready(r, fl, ordy);
        if (!r || fl) begin
            m_data.delete();
            m_pos.delete();
            if (!r) known = 1;
            return;
        end
        dlv = model_valid() && ordy;
        if (dlv) begin
            void'(m_data.pop_front());
            void'(m_pos.pop_front());
        end
        // Every word moves one slot unless packed against the words ahead of it.
        for (int j = 0; j < m_pos.size(); j++) begin
            int lim;
            lim = int'(STAGES) - 1 - j;
            m_pos[j] = (m_pos[j] + 1 < lim) ? m_pos[j] + 1 : lim;
        end
        if (acc) begin
            m_data.push_back(int'(id));
            m_pos.push_back(0);
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, update model, pass the rising edge.
    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] id,
                        input logic fl, input logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        check_eq("in_ready", int'(in_ready), int'(model_in_ready(r, fl, ordy)));
        if (known) begin
            check_eq("out_valid", int'(out_valid), int'(model_valid()));
            check_eq("occupancy", int'(occupancy), m_data.size());
            if (model_valid()) check_eq("out_data", int'(out_data), m_data[0]);
        end
        if (out_valid && out_ready) dut_deliv++;
        model_edge(r, iv, id, fl, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (STAGES + 2) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset with in_valid held high.
        repeat (2) step(1'b0, 1'b1, 8'(($urandom)), 1'b0, 1'b1);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'(out_data), 8'h00);
        check_eq("rst_occ", int'(occupancy), 0);
        check_eq("rst_in_ready", int'(in_ready), 0);

        // Streaming 30 words with the consumer always ready.
        dut_deliv = 0;
        for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
        drain();
        check_eq("stream_count", dut_deliv, 30);

        // Backpressure: fill A1..A4, stall 5 cycles, then release.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'(8'hA1 + k), 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("stall_in_ready", int'(in_ready), 0);
        check_eq("stall_out_data", int'(out_data), 8'hA1);
        check_eq("stall_occ", int'(occupancy), 4);
        drain();

        // Bubble collapse behind a stalled output.
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("bubble_occ", int'(occupancy), 2);
        check_eq("bubble_out_data", int'(out_data), 8'h11);
        check_eq("bubble_out_valid", int'(out_valid), 1);
        drain();

        // Flush with three words in flight and a word offered in the flush cycle.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("flush_occ", int'(occupancy), 0);
        check_eq("flush_out_valid", int'(out_valid), 0);
        check_eq("flush_out_data", int'(out_data), 8'h00);
        drain();

        // Reset mid-stream with three words in flight.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
        check_eq("pre_rst_occ", int'(occupancy), 3);
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        check_eq("midrst_occ", int'(occupancy), 0);
        check_eq("midrst_out_valid", int'(out_valid), 0);
        drain();

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 600; k++) begin
            logic r, iv, fl, ordy;
            r    = ($urandom_range(99) != 0);
            iv   = ($urandom_range(99) < 70);
            fl   = ($urandom_range(99) < 3);
            ordy = ($urandom_range(99) < 55);
            step(r, iv, 8'($urandom), fl, ordy);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dff_pipeline
